regfile_wb_arbiter: RTL and testbench
=====================================

// Module: regfile_wb_arbiter
// PURPOSE
//   Writeback stage directly upstream of regfile. Merges ALU results (single-cycle) and
//   multdiv results (multi-cycle, bursty) onto the single regfile write port.
//   ALU has priority; multdiv results wait in a DEPTH-entry FIFO.
//   Read data from the regfile is forwarded with still-pending writes so decode sees current values.
// PARAMETERS
//   DEPTH  4   multdiv FIFO entries (power of 2, >=2)
//   DW     32  data width
// PORTS
//   clock            in   1   rising-edge clock
//   ctrl_reset       in   1   synchronous, active-high reset
//   alu_valid        in   1   ALU result valid this cycle
//   alu_reg          in   5   ALU destination register
//   alu_data         in   DW  ALU result
//   md_valid         in   1   multdiv result valid this cycle
//   md_reg           in   5   multdiv destination register
//   md_data          in   DW  multdiv result
//   md_ready         out  1   FIFO can accept: !full, from registered count
//   ctrl_writeEn     out  1   to regfile write enable (registered)
//   ctrl_writeReg    out  5   to regfile write address (registered)
//   data_writeReg    out  DW  to regfile write data (registered)
//   ctrl_readRegA/B  in   5   decode read addresses, also driven to regfile
//   rf_readRegA/B    in   DW  raw regfile read data
//   data_readRegA/B  out  DW  forwarded read data to decode
// BEHAVIOUR
//   Reset (sync, edge with ctrl_reset=1): FIFO count=0, rd/wr ptrs=0, all valid bits=0,
//     ctrl_writeEn=0, ctrl_writeReg=0, data_writeReg=0, md_ready=1 next cycle.
//     Reset overrides all same-edge pushes and pops. In-flight entries are lost.
//   Write select at each edge, stored in the output register:
//     1) alu_valid && alu_reg!=0 -> output <= ALU; FIFO not popped.
//     2) else FIFO head valid    -> output <= head; pop.
//     3) else                    -> ctrl_writeEn <= 0; writeReg/data hold their last value.
//   Latency: ALU accepted at edge N -> ctrl_writeEn=1 in cycle N+1; regfile captures at edge N+1.
//     md pushed at edge N: earliest writeEn is cycle N+2.
//   Push: md_valid && md_ready && md_reg!=0 -> enqueue at tail.
//     md_valid with md_ready=0 is ignored; the producer must hold.
//     md_reg==0 is accepted and discarded.
//   Full boundary: md_ready uses the registered count only.
//     When full, no push occurs even if a pop happens on the same edge.
//     Push and pop on one edge when not full: count unchanged.
//   Empty FIFO: no pop.
//   Pointers wrap modulo DEPTH.
//   Ordering: an ALU write is younger than every multdiv result.
//     When an ALU write to R is accepted, every FIFO entry with reg R has its valid bit cleared.
//     A same-edge md push with md_reg==R is also cleared.
//     Invalid (killed) entries still occupy slots. When one reaches the head it is popped with no write,
//       and priority 2 evaluates the new head on the next edge.
//   Register 0: writeEn is never asserted for reg 0. Forwarding never applies to reg 0 (returns rf data).
//   Forwarding, per port, combinational, priority order:
//     a) youngest valid FIFO entry with reg==addr
//     b) output register when ctrl_writeEn && ctrl_writeReg==addr
//     c) rf_readReg
//   Ports A and B are independent. Both may forward the same entry.
// TESTING
//   Reset 2 cycles, idle -> writeEn=0, md_ready=1, data_readRegA = rf data for all 32 addresses.
//   ALU writes r5=0x00000005 at edge N -> cycle N+1: writeEn=1, writeReg=5, data=5.
//     Read r5 in cycle N+1 -> 0x5 (forwarded).
//   md pushes r3=0xAAAA0003 and r4=0xAAAA0004 while alu_valid=1 for 3 cycles
//     -> no md write during ALU cycles; then r3, r4 written on consecutive cycles in order.
//   Push DEPTH md results with ALU busy -> md_ready=0. Next md_valid ignored.
//     Release ALU -> DEPTH writes, md_ready=1 one cycle after first pop.
//   FIFO holds r7=0x11 (md); ALU writes r7=0x22 -> r7 entry killed.
//     No later write of 0x11; read r7 -> 0x22 throughout.
//   ALU/md target r0; assert reset mid-drain with 2 entries queued
//     -> no writeEn for r0; after reset writeEn=0, count=0, no stale writes.

Source files
------------

// File: rtl/regfile_wb_arbiter.sv
// Writeback arbiter in front of the regfile: ALU results win the single write port,
// multdiv results queue in a small FIFO, and decode reads see still-pending writes.
module regfile_wb_arbiter #(
  parameter int DEPTH = 4,
  parameter int DW    = 32
) (
  input  logic          clock,
  input  logic          ctrl_reset,
  input  logic          alu_valid,
  input  logic [4:0]    alu_reg,
  input  logic [DW-1:0] alu_data,
  input  logic          md_valid,
  input  logic [4:0]    md_reg,
  input  logic [DW-1:0] md_data,
  output logic          md_ready,
  output logic          ctrl_writeEn,
  output logic [4:0]    ctrl_writeReg,
  output logic [DW-1:0] data_writeReg,
  input  logic [4:0]    ctrl_readRegA,
  input  logic [4:0]    ctrl_readRegB,
  input  logic [DW-1:0] rf_readRegA,
  input  logic [DW-1:0] rf_readRegB,
  output logic [DW-1:0] data_readRegA,
  output logic [DW-1:0] data_readRegB
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0]    rdPtr, wrPtr;
  logic [CW-1:0]    count;
  logic [4:0]       regQ  [DEPTH];
  logic [DW-1:0]    dataQ [DEPTH];
  logic [DEPTH-1:0] validQ;

  logic aluAcc, notEmpty, headValid, pop, push;

  assign aluAcc    = alu_valid && (alu_reg != 5'd0);
  assign notEmpty  = (count != '0);
  assign headValid = notEmpty && validQ[rdPtr];
  // Killed heads are still popped; they just produce no write.
  assign pop       = !aluAcc && notEmpty;
  assign md_ready  = (count != CW'(DEPTH));
  assign push      = md_valid && md_ready && (md_reg != 5'd0);

  always_ff @(posedge clock) begin
    if (ctrl_reset) begin
      rdPtr         <= '0;
      wrPtr         <= '0;
      count         <= '0;
      validQ        <= '0;
      ctrl_writeEn  <= 1'b0;
      ctrl_writeReg <= '0;
      data_writeReg <= '0;
    end else begin
      if (aluAcc) begin
        ctrl_writeEn  <= 1'b1;
        ctrl_writeReg <= alu_reg;
        data_writeReg <= alu_data;
      end else if (pop && headValid) begin
        ctrl_writeEn  <= 1'b1;
        ctrl_writeReg <= regQ[rdPtr];
        data_writeReg <= dataQ[rdPtr];
      end else begin
        ctrl_writeEn  <= 1'b0;
      end

      // The ALU write is younger than anything queued, so queued writes to that reg are dead.
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (aluAcc && regQ[PW'(i)] == alu_reg)
          validQ[PW'(i)] <= 1'b0;
      end

      if (pop) begin
        validQ[rdPtr] <= 1'b0;
        rdPtr         <= rdPtr + 1'b1;
      end

      if (push) begin
        regQ[wrPtr]   <= md_reg;
        dataQ[wrPtr]  <= md_data;
        validQ[wrPtr] <= !(aluAcc && md_reg == alu_reg);
        wrPtr         <= wrPtr + 1'b1;
      end

      count <= count + CW'(push) - CW'(pop);
    end
  end

  function automatic logic [DW-1:0] fwd(input logic [4:0] addr, input logic [DW-1:0] rf);
    logic [DW-1:0] r;
    logic [PW-1:0] idx;
    r = rf;
    if (ctrl_writeEn && ctrl_writeReg == addr)
      r = data_writeReg;
    // Walk oldest to youngest so the youngest match wins.
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx = rdPtr + PW'(k);
      if (CW'(k) < count && validQ[idx] && regQ[idx] == addr)
        r = dataQ[idx];
    end
    if (addr == 5'd0)
      r = rf;
    return r;
  endfunction

  always_comb begin
    data_readRegA = fwd(ctrl_readRegA, rf_readRegA);
    data_readRegB = fwd(ctrl_readRegB, rf_readRegB);
  end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed + random bench for regfile_wb_arbiter: a queue model of the multdiv FIFO
// feeds an expected-write scoreboard, and a behavioural regfile backs the read ports.
module tb_regfile_wb_arbiter;
  localparam int DEPTH = 4;
  localparam int DW    = 32;

  logic          clock;
  logic          ctrl_reset;
  logic          alu_valid, md_valid;
  logic [4:0]    alu_reg, md_reg;
  logic [DW-1:0] alu_data, md_data;
  logic          md_ready, ctrl_writeEn;
  logic [4:0]    ctrl_writeReg;
  logic [DW-1:0] data_writeReg;
  logic [4:0]    ctrl_readRegA, ctrl_readRegB;
  logic [DW-1:0] rf_readRegA, rf_readRegB, data_readRegA, data_readRegB;

  regfile_wb_arbiter #(.DEPTH(DEPTH), .DW(DW)) dut (
    .clock(clock), .ctrl_reset(ctrl_reset),
    .alu_valid(alu_valid), .alu_reg(alu_reg), .alu_data(alu_data),
    .md_valid(md_valid), .md_reg(md_reg), .md_data(md_data), .md_ready(md_ready),
    .ctrl_writeEn(ctrl_writeEn), .ctrl_writeReg(ctrl_writeReg), .data_writeReg(data_writeReg),
    .ctrl_readRegA(ctrl_readRegA), .ctrl_readRegB(ctrl_readRegB),
    .rf_readRegA(rf_readRegA), .rf_readRegB(rf_readRegB),
    .data_readRegA(data_readRegA), .data_readRegB(data_readRegB)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  logic [31:0] rfMem [32];
  always @(posedge clock)
    if (ctrl_writeEn === 1'b1 && ctrl_writeReg != 5'd0)
      rfMem[ctrl_writeReg] <= data_writeReg;
  assign rf_readRegA = rfMem[ctrl_readRegA];
  assign rf_readRegB = rfMem[ctrl_readRegB];

  typedef struct packed { logic [4:0] r; logic [31:0] d; logic v; } ent_t;
  typedef struct packed { logic [4:0] r; logic [31:0] d; } wr_t;
  ent_t mdq[$];
  wr_t  expQ[$];
  logic        lastV;
  logic [4:0]  lastR;
  logic [31:0] lastD;
  int nAsserts = 0;
  int nFails   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nAsserts++;
    assert (obs === exp) else begin
      nFails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] fwd(input logic [4:0] a);
    logic [31:0] r;
    r = rfMem[a];
    if (a == 5'd0) return r;
    if (lastV && lastR == a) r = lastD;
    foreach (mdq[i]) if (mdq[i].v && mdq[i].r == a) r = mdq[i].d;
    return r;
  endfunction

  task automatic drive(input logic aV, input logic [4:0] aR, input logic [31:0] aD,
                       input logic mV, input logic [4:0] mR, input logic [31:0] mD);
    alu_valid = aV; alu_reg = aR; alu_data = aD;
    md_valid = mV;  md_reg = mR;  md_data = mD;
  endtask

  // Model one clock edge from the current inputs, then check outputs and both read ports.
  task automatic step();
    int   sz;
    logic acc;
    ent_t h;
    wr_t  w;
    sz  = mdq.size();
    acc = alu_valid && alu_reg != 5'd0;
    if (acc) begin
      expQ.push_back('{r: alu_reg, d: alu_data});
      foreach (mdq[i]) if (mdq[i].r == alu_reg) mdq[i].v = 1'b0;
    end else if (sz > 0) begin
      h = mdq.pop_front();
      if (h.v) expQ.push_back('{r: h.r, d: h.d});
    end
    if (md_valid && sz < DEPTH && md_reg != 5'd0)
      mdq.push_back('{r: md_reg, d: md_data, v: !(acc && md_reg == alu_reg)});
    if (ctrl_reset) begin
      mdq.delete();
      expQ.delete();
    end
    @(posedge clock);
    #1;
    check("writeEn", 32'(ctrl_writeEn), 32'(expQ.size() != 0));
    lastV = 1'b0;
    if (expQ.size() != 0) begin
      w = expQ.pop_front();
      check("writeReg", 32'(ctrl_writeReg), 32'(w.r));
      check("writeData", data_writeReg, w.d);
      lastV = 1'b1; lastR = w.r; lastD = w.d;
    end
    check("md_ready", 32'(md_ready), 32'(mdq.size() < DEPTH));
    check("readA", data_readRegA, fwd(ctrl_readRegA));
    check("readB", data_readRegB, fwd(ctrl_readRegB));
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rfMem[i] = 32'hF000_0000 | 32'(i);
    lastV = 1'b0; lastR = '0; lastD = '0;
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd0;
    drive(0, 0, 0, 0, 0, 0);

    // Reset for two cycles, then idle reads return raw regfile data.
    ctrl_reset = 1'b1;
    step(); step();
    ctrl_reset = 1'b0;
    step();
    check("rst_writeEn", 32'(ctrl_writeEn), 32'd0);
    check("rst_md_ready", 32'(md_ready), 32'd1);
    for (int i = 0; i < 32; i++) begin
      ctrl_readRegA = 5'(i);
      #1;
      check("rst_readA", data_readRegA, 32'hF000_0000 | 32'(i));
    end

    // ALU write to r5, forwarded in the following cycle.
    ctrl_readRegA = 5'd5; ctrl_readRegB = 5'd3;
    drive(1, 5'd5, 32'h5, 0, 0, 0);
    step();
    check("alu_writeReg", 32'(ctrl_writeReg), 32'd5);
    check("alu_fwd_r5", data_readRegA, 32'h5);

    // multdiv results wait behind three ALU cycles, then drain in order.
    drive(1, 5'd10, 32'h10, 1, 5'd3, 32'hAAAA_0003); step();
    check("md_fwd_r3", data_readRegB, 32'hAAAA_0003);
    drive(1, 5'd11, 32'h11, 1, 5'd4, 32'hAAAA_0004); step();
    drive(1, 5'd12, 32'h12, 0, 0, 0); step();
    drive(0, 0, 0, 0, 0, 0); step();
    check("md_first_r3", 32'(ctrl_writeReg), 32'd3);
    step();
    check("md_second_r4", data_writeReg, 32'hAAAA_0004);
    step();

    // Fill the FIFO while the ALU is busy; an extra push is ignored.
    ctrl_readRegA = 5'd20; ctrl_readRegB = 5'd24;
    for (int i = 0; i < DEPTH; i++) begin
      drive(1, 5'd1, 32'(i), 1, 5'(20 + i), 32'hBB00_0000 | 32'(i));
      step();
    end
    check("full_md_ready", 32'(md_ready), 32'd0);
    drive(1, 5'd1, 32'h99, 1, 5'd24, 32'hDEAD_0024); step();
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) step();
    check("no_r24_write", data_readRegB, 32'hF000_0018);

    // Queued r7 killed by a younger ALU write to r7.
    ctrl_readRegA = 5'd7; ctrl_readRegB = 5'd7;
    drive(1, 5'd1, 32'h1, 1, 5'd7, 32'h11); step();
    check("pre_kill_r7", data_readRegA, 32'h11);
    drive(1, 5'd7, 32'h22, 0, 0, 0); step();
    check("kill_fwd_r7", data_readRegA, 32'h22);
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("kill_hold_r7", data_readRegB, 32'h22);
    end

    // Register 0 is never written; reset mid-drain drops queued entries.
    ctrl_readRegA = 5'd0; ctrl_readRegB = 5'd9;
    drive(1, 5'd0, 32'h77, 1, 5'd0, 32'h88); step();
    check("r0_no_write", 32'(ctrl_writeEn), 32'd0);
    drive(1, 5'd1, 32'h2, 1, 5'd8, 32'hCC08); step();
    drive(1, 5'd1, 32'h3, 1, 5'd9, 32'hCC09); step();
    drive(1, 5'd1, 32'h4, 1, 5'd10, 32'hCC0A); step();
    drive(0, 0, 0, 0, 0, 0); step();
    ctrl_reset = 1'b1; step();
    ctrl_reset = 1'b0;
    check("rst_mid_writeEn", 32'(ctrl_writeEn), 32'd0);
    for (int i = 0; i < 4; i++) step();
    check("no_stale_r9", data_readRegB, 32'hF000_0009);

    // Random traffic over a small register set to exercise kills and wrap.
    for (int i = 0; i < 120; i++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
      ctrl_readRegA = 5'($urandom_range(0, 7));
      ctrl_readRegB = 5'($urandom_range(0, 7));
      step();
    end
    drive(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < DEPTH + 2; i++) step();
    check("drained", 32'(mdq.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end
endmodule
